waveform_monitor: RTL and testbench
===================================

// Module: waveform_monitor
// PURPOSE
//   Consumes the 8-bit sample stream produced by the ROM waveform generators.
//   Measures, per waveform cycle, the period in samples, the min, the max and
//   the peak-to-peak amplitude. Results go to the display/debug logic.
//   Triggers on rising mid-scale crossings.
// PARAMETERS
//   DATA_W    8      sample width (unsigned, offset-binary)
//   MID       128    crossing threshold (mid-scale)
//   HYST      8      hysteresis half-band, used only when WMON_HYST_EN is defined
//   PERIOD_W  16     width of the period counter and output
//   TIMEOUT   65535  samples without a crossing before abort (< 2**PERIOD_W)
// PORTS
//   clk           in   1         system clock, rising edge
//   rst_n         in   1         asynchronous active-low reset
//   enable        in   1         1 = run; 0 = return to IDLE
//   sample_valid  in   1         sample_data is valid this cycle
//   sample_data   in   DATA_W    sample from the generator
//   period        out  PERIOD_W  last measured period, in samples
//   vmin          out  DATA_W    minimum sample in the last period
//   vmax          out  DATA_W    maximum sample in the last period
//   vpp           out  DATA_W    vmax - vmin
//   meas_valid    out  1         1-cycle pulse: new results were published
//   locked        out  1         two consecutive equal periods were seen
//   timeout_err   out  1         1-cycle pulse: TIMEOUT reached in MEASURE
// BEHAVIOUR
//   Reset
//     - All outputs are 0.
//     - State = IDLE. prev_sample = 0. Counters are cleared.
//   Sample processing
//     - Only cycles with sample_valid=1 are processed.
//     - Idle cycles change nothing except the 1-cycle pulses, which self-clear.
//   Rising crossing (no macro)
//     - Crossing = prev_sample < MID and sample_data >= MID.
//     - prev_sample updates on every accepted sample, in every state except IDLE.
//   State IDLE
//     - Entered when enable=0, from any state, on the next clk.
//     - locked is cleared. period/vmin/vmax/vpp hold their values.
//     - enable=1 -> ARM.
//   State ARM
//     - Waits for the first crossing.
//     - On a crossing -> MEASURE with cnt=1, min=max=sample.
//   State MEASURE, accepted sample without a crossing
//     - cnt += 1. min and max are updated (unsigned compare).
//   State MEASURE, accepted sample with a crossing
//     - Publish next cycle: period=cnt, vmin=min, vmax=max, vpp=max-min.
//     - meas_valid pulses for exactly 1 cycle.
//     - In the same cycle a new window starts: cnt=1, min=max=sample.
//       Measurements therefore run back-to-back with no lost sample.
//   Latency
//     - meas_valid is asserted in the cycle after the crossing sample is
//       accepted.
//   Lock
//     - locked=1 when the period just published equals the previous one.
//     - It is cleared on a mismatch, on a timeout, or in IDLE.
//     - The first publish after ARM never sets locked.
//   Timeout
//     - If cnt reaches TIMEOUT in MEASURE: timeout_err pulses for 1 cycle.
//     - locked is cleared and the state goes to ARM.
//     - Results are not published, and the counter never wraps.
//   Simultaneous events
//     - enable falling has priority over a crossing or a timeout in the same
//       cycle. Nothing is published.
//   Reset mid-operation
//     - Asynchronous reset of all state; the partial window is discarded.
// CONFIGURATION
//   WMON_HYST_EN defined
//     - Uses a Schmitt-style trigger instead of prev_sample.
//     - An "armed" flag is set when sample < MID-HYST.
//     - A crossing is sample >= MID+HYST while armed; it clears armed.
//     - This rejects noise around MID.
//     - Reset value of armed = 0. IDLE clears armed.
//   WMON_HYST_EN undefined
//     - The plain prev_sample compare above is used, with no hysteresis logic.
// TESTING
//   1. Input: 10-sample table 80,CB,F9,F9,CB,80,34,06,06,34 (hex), repeated,
//      sample_valid=1 every cycle.
//      -> period=10, vmin=06, vmax=F9, vpp=F3.
//      -> meas_valid every 10 cycles; locked=1 from the 2nd publish on.
//   2. Same table, sample_valid=1 every 3rd cycle.
//      -> period=10, with meas_valid every 30 clk.
//   3. Constant input 0x40, TIMEOUT=32, enable=1.
//      -> no meas_valid, and timeout_err never fires (stays in ARM).
//      Then present one crossing, then hold 0x90 for 32 samples.
//      -> timeout_err pulses once; locked=0.
//   4. A 10-sample table alternating with a 12-sample table.
//      -> periods 10,12,10,...; locked stays 0.
//   5. Drop enable, or assert rst_n=0, in mid-window.
//      -> outputs hold (enable) or go to 0 (reset).
//      -> no meas_valid; after re-arming, the first publish is correct.
//   6. WMON_HYST_EN defined, HYST=8, with +/-4 LSB noise around 0x80 on test 1.
//      -> period still 10, no spurious meas_valid.

Source files
------------

// File: rtl/waveform_monitor.sv
// Per-cycle period / min / max / peak-to-peak monitor for the 8-bit waveform sample stream.
// Define WMON_HYST_EN to replace the plain mid-scale crossing with a Schmitt-style trigger.
module waveform_monitor #(
    parameter int DATA_W   = 8,
    parameter int MID      = 128,
    parameter int HYST     = 8,
    parameter int PERIOD_W = 16,
    parameter int TIMEOUT  = 65535
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                sample_valid,
    input  logic [DATA_W-1:0]   sample_data,
    output logic [PERIOD_W-1:0] period,
    output logic [DATA_W-1:0]   vmin,
    output logic [DATA_W-1:0]   vmax,
    output logic [DATA_W-1:0]   vpp,
    output logic                meas_valid,
    output logic                locked,
    output logic                timeout_err
);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEAS} state_t;

    localparam logic [DATA_W-1:0]   MID_V    = DATA_W'(MID);
    localparam logic [PERIOD_W-1:0] TMO_LAST = PERIOD_W'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]   min_q, min_d, max_q, max_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [DATA_W-1:0]   vmin_q, vmin_d, vmax_q, vmax_d, vpp_q, vpp_d;
    logic                meas_valid_q, meas_valid_d;
    logic                locked_q, locked_d;
    logic                timeout_err_q, timeout_err_d;
    logic                have_prev_q, have_prev_d;
    logic                crossing;

`ifdef WMON_HYST_EN
    localparam logic [DATA_W-1:0] HI_V = DATA_W'(MID + HYST);
    localparam logic [DATA_W-1:0] LO_V = DATA_W'(MID - HYST);
    logic armed_q, armed_d;

    assign crossing = armed_q && (sample_data >= HI_V);
`else
    logic [DATA_W-1:0] prev_q, prev_d;

    assign crossing = (prev_q < MID_V) && (sample_data >= MID_V);
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        min_d         = min_q;
        max_d         = max_q;
        period_d      = period_q;
        vmin_d        = vmin_q;
        vmax_d        = vmax_q;
        vpp_d         = vpp_q;
        meas_valid_d  = 1'b0;
        locked_d      = locked_q;
        timeout_err_d = 1'b0;
        have_prev_d   = have_prev_q;
`ifdef WMON_HYST_EN
        armed_d       = armed_q;
`else
        prev_d        = prev_q;
`endif
        case (state_q)
            S_IDLE: begin
                locked_d    = 1'b0;
                have_prev_d = 1'b0;
`ifdef WMON_HYST_EN
                armed_d     = 1'b0;
`endif
                if (enable) state_d = S_ARM;
            end
            default: begin
                if (sample_valid) begin
`ifdef WMON_HYST_EN
                    if (crossing)               armed_d = 1'b0;
                    else if (sample_data < LO_V) armed_d = 1'b1;
`else
                    prev_d = sample_data;
`endif
                end
                // Disable wins over any crossing or timeout seen in the same cycle.
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (sample_valid) begin
                    if (crossing) begin
                        if (state_q == S_MEAS) begin
                            period_d     = cnt_q;
                            vmin_d       = min_q;
                            vmax_d       = max_q;
                            vpp_d        = max_q - min_q;
                            meas_valid_d = 1'b1;
                            locked_d     = have_prev_q && (cnt_q == period_q);
                            have_prev_d  = 1'b1;
                        end
                        // The crossing sample opens the next window, so nothing is lost.
                        state_d = S_MEAS;
                        cnt_d   = PERIOD_W'(1);
                        min_d   = sample_data;
                        max_d   = sample_data;
                    end else if (state_q == S_MEAS) begin
                        if (cnt_q == TMO_LAST) begin
                            timeout_err_d = 1'b1;
                            locked_d      = 1'b0;
                            have_prev_d   = 1'b0;
                            cnt_d         = '0;
                            state_d       = S_ARM;
                        end else begin
                            cnt_d = cnt_q + PERIOD_W'(1);
                            if (sample_data < min_q) min_d = sample_data;
                            if (sample_data > max_q) max_d = sample_data;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            min_q         <= '0;
            max_q         <= '0;
            period_q      <= '0;
            vmin_q        <= '0;
            vmax_q        <= '0;
            vpp_q         <= '0;
            meas_valid_q  <= 1'b0;
            locked_q      <= 1'b0;
            timeout_err_q <= 1'b0;
            have_prev_q   <= 1'b0;
`ifdef WMON_HYST_EN
            armed_q       <= 1'b0;
`else
            prev_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            min_q         <= min_d;
            max_q         <= max_d;
            period_q      <= period_d;
            vmin_q        <= vmin_d;
            vmax_q        <= vmax_d;
            vpp_q         <= vpp_d;
            meas_valid_q  <= meas_valid_d;
            locked_q      <= locked_d;
            timeout_err_q <= timeout_err_d;
            have_prev_q   <= have_prev_d;
`ifdef WMON_HYST_EN
            armed_q       <= armed_d;
`else
            prev_q        <= prev_d;
`endif
        end
    end

    assign period      = period_q;
    assign vmin        = vmin_q;
    assign vmax        = vmax_q;
    assign vpp         = vpp_q;
    assign meas_valid  = meas_valid_q;
    assign locked      = locked_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_waveform_monitor.sv
// Scoreboard bench for waveform_monitor: expected publishes are queued as crossing
// samples are driven and checked when meas_valid fires.
module tb_waveform_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        sample_valid = 1'b0;
    logic [7:0]  sample_data = 8'h00;
    logic [15:0] period;
    logic [7:0]  vmin, vmax, vpp;
    logic        meas_valid, locked, timeout_err;

    waveform_monitor #(.TIMEOUT(32)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .sample_valid(sample_valid), .sample_data(sample_data),
        .period(period), .vmin(vmin), .vmax(vmax), .vpp(vpp),
        .meas_valid(meas_valid), .locked(locked), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] p;
        logic [7:0]  mn;
        logic [7:0]  mx;
        logic [7:0]  pp;
        logic        lk;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_mv = -1;
    int   exp_gap = 0;
    int   to_cnt = 0;

    logic [7:0] tbl_a[10] = '{8'h80, 8'hCB, 8'hF9, 8'hF9, 8'hCB, 8'h80, 8'h34, 8'h06, 8'h06, 8'h34};
    logic [7:0] tbl_b[12] = '{8'h80, 8'hB0, 8'hE0, 8'hFF, 8'hE0, 8'hB0,
                              8'h80, 8'h50, 8'h20, 8'h00, 8'h20, 8'h50};

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (timeout_err) to_cnt++;
            if (meas_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL spurious_publish: got period=%0d vmin=%h vmax=%h, required no meas_valid",
                             period, vmin, vmax);
                end else begin
                    e = exp_q.pop_front();
                    if ({period, vmin, vmax, vpp, locked} !== {e.p, e.mn, e.mx, e.pp, e.lk}) begin
                        bad++;
                        $display("FAIL publish: got p=%0d min=%h max=%h pp=%h lk=%b, required p=%0d min=%h max=%h pp=%h lk=%b",
                                 period, vmin, vmax, vpp, locked, e.p, e.mn, e.mx, e.pp, e.lk);
                    end
                end
                if (exp_gap != 0 && last_mv >= 0) begin
                    total++;
                    if (cyc - last_mv !== exp_gap) begin
                        bad++;
                        $display("FAIL publish_spacing: got %0d clk, required %0d", cyc - last_mv, exp_gap);
                    end
                end
                last_mv = cyc;
            end
        end
    endtask

    task automatic push(input int p, input logic [7:0] mn, input logic [7:0] mx, input logic lk);
        exp_t e;
        e.p  = 16'(p);
        e.mn = mn;
        e.mx = mx;
        e.pp = mx - mn;
        e.lk = lk;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] d, input int gap);
        sample_data  = d;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic drain(input string name);
        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL %s_missing_publish: %0d expected results never published", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic rearm();
        enable = 1'b0;
        repeat (2) @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        exp_gap = 0;
        last_mv = -1;
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %b, required %b", name, got, want);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({period, vmin, vmax, vpp, meas_valid, locked, timeout_err} !== 43'd0) begin
            bad++;
            $display("FAIL reset_outputs: got p=%0d min=%h max=%h pp=%h mv=%b lk=%b to=%b, required all 0",
                     period, vmin, vmax, vpp, meas_valid, locked, timeout_err);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        enable = 1'b1;
        @(negedge clk);
        exp_gap = 10;
        last_mv = -1;
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 10; j++) begin
                if (i > 0 && j == 0) push(10, 8'h06, 8'hF9, i > 1);
                send(tbl_a[j], 0);
            end
        push(10, 8'h06, 8'hF9, 1'b1);
        send(8'h80, 0);
        drain("basic");
        check_bit("basic_locked", locked, 1'b1);
    endtask

    task automatic test_sparse();
        rearm();
        check_bit("idle_clears_locked", locked, 1'b0);
        exp_gap = 30;
        send(8'h00, 2);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 10; j++) begin
                if (i > 0 && j == 0) push(10, 8'h06, 8'hF9, i > 1);
                send(tbl_a[j], 2);
            end
        push(10, 8'h06, 8'hF9, 1'b1);
        send(8'h80, 2);
        drain("sparse");
    endtask

    task automatic test_timeout();
        int base;
        rearm();
        base = to_cnt;
        repeat (40) send(8'h40, 0);
        total++;
        if (to_cnt !== base) begin
            bad++;
            $display("FAIL arm_no_timeout: got %0d pulses, required 0", to_cnt - base);
        end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 10; j++) begin
                if (i > 0 && j == 0) push(10, 8'h06, 8'hF9, i > 1);
                send(tbl_a[j], 0);
            end
        push(10, 8'h06, 8'hF9, 1'b1);
        send(8'h80, 0);
        repeat (30) send(8'h90, 0);
        repeat (2) @(negedge clk);
        check_bit("pre_timeout_locked", locked, 1'b1);
        total++;
        if (to_cnt !== base) begin
            bad++;
            $display("FAIL early_timeout: got %0d pulses after 31 samples, required 0", to_cnt - base);
        end
        repeat (4) send(8'h90, 0);
        repeat (3) @(negedge clk);
        total++;
        if (to_cnt !== base + 1) begin
            bad++;
            $display("FAIL timeout_pulse: got %0d pulses, required 1", to_cnt - base);
        end
        check_bit("timeout_clears_locked", locked, 1'b0);
        drain("timeout");
    endtask

    task automatic test_alternate();
        rearm();
        send(8'h00, 0);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                if (k % 2 == 1) push(10, 8'h06, 8'hF9, 1'b0);
                else            push(12, 8'h00, 8'hFF, 1'b0);
            end
            if (k % 2 == 0) for (int j = 0; j < 10; j++) send(tbl_a[j], 0);
            else            for (int j = 0; j < 12; j++) send(tbl_b[j], 0);
        end
        push(10, 8'h06, 8'hF9, 1'b0);
        send(8'h80, 0);
        drain("alternate");
        check_bit("alternate_locked", locked, 1'b0);
    endtask

    task automatic test_abort();
        rearm();
        send(8'h00, 0);
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 10; j++) begin
                if (i > 0 && j == 0) push(10, 8'h06, 8'hF9, 1'b0);
                send(tbl_a[j], 0);
            end
        push(10, 8'h06, 8'hF9, 1'b1);
        send(8'h80, 0);
        for (int j = 1; j < 6; j++) send(tbl_a[j], 0);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({period, vmin, vmax, vpp} !== {16'd10, 8'h06, 8'hF9, 8'hF3}) begin
            bad++;
            $display("FAIL disable_hold: got p=%0d min=%h max=%h pp=%h, required p=10 min=06 max=f9 pp=f3",
                     period, vmin, vmax, vpp);
        end
        check_bit("disable_locked", locked, 1'b0);
        enable = 1'b1;
        @(negedge clk);
        send(8'h00, 0);
        for (int j = 0; j < 10; j++) send(tbl_a[j], 0);
        push(10, 8'h06, 8'hF9, 1'b0);
        send(8'h80, 0);
        send(8'hCB, 0);
        send(8'hF9, 0);
        drain("rearm_after_disable");
        rst_n = 1'b0;
        #1;
        total++;
        if ({period, vmin, vmax, vpp, meas_valid, locked, timeout_err} !== 43'd0) begin
            bad++;
            $display("FAIL midwindow_reset: got p=%0d min=%h max=%h pp=%h lk=%b, required all 0",
                     period, vmin, vmax, vpp, locked);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send(8'h00, 0);
        for (int j = 0; j < 10; j++) send(tbl_a[j], 0);
        push(10, 8'h06, 8'hF9, 1'b0);
        send(8'h80, 0);
        drain("rearm_after_reset");
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_basic();
        test_sparse();
        test_timeout();
        test_alternate();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
